// File: rtl/v_vram_arbiter_pkg.sv
// Shared widths, FSM encoding and master ids for the two-master VRAM arbiter.
package v_vram_arbiter_pkg;

    localparam int unsigned VramAddrW = 64;
    localparam int unsigned VramDataW = 256;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } arb_state_e;

    localparam logic MLsu = 1'b0;
    localparam logic MWb  = 1'b1;

    function automatic logic other_m(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/v_vram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, ties go to ptr_i.
module v_vram_arbiter_rr_pick2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/v_vram_arbiter.sv
// Shares the single VRAM port between the vector LSU (M0) and writeback/spill path (M1),
// with burst locking and 1-cycle read response routing.
module v_vram_arbiter
    import v_vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = VramAddrW,
    parameter int unsigned DATA_W = VramDataW,
    parameter int unsigned NUM_M  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req_valid,
    output logic [NUM_M-1:0]        m_req_ready,
    input  logic [NUM_M-1:0]        m_req_we,
    input  logic [NUM_M-1:0]        m_req_last,
    input  logic [NUM_M*ADDR_W-1:0] m_req_addr,
    input  logic [NUM_M*DATA_W-1:0] m_req_wdata,
    input  logic [NUM_M*DATA_W-1:0] m_req_wmask,
    output logic [NUM_M-1:0]        m_rsp_valid,
    output logic [DATA_W-1:0]       m_rsp_data,
    output logic                    vram_r_ena,
    output logic [ADDR_W-1:0]       vram_r_addr,
    input  logic [DATA_W-1:0]       vram_r_data,
    output logic                    vram_w_ena,
    output logic [ADDR_W-1:0]       vram_w_addr,
    output logic [DATA_W-1:0]       vram_w_data,
    output logic [DATA_W-1:0]       vram_w_mask
);

    arb_state_e state_q, state_d;
    logic owner_q, owner_d;
    logic rr_ptr_q, rr_ptr_d;
    logic tag_valid_q, tag_valid_d;
    logic tag_id_q, tag_id_d;

    logic [1:0]        rr_grant;
    logic [1:0]        grant;
    logic              any_grant;
    logic              sel;
    logic              sel_we;
    logic              sel_last;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] sel_wmask;

    v_vram_arbiter_rr_pick2 u_pick (
        .valid_i (m_req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant)
    );

    // While locked only the owner can be granted, and only when it is valid.
    always_comb begin
        grant = '0;
        if (state_q == StIdle) begin
            grant = rr_grant;
        end else begin
            grant[owner_q] = m_req_valid[owner_q];
        end
    end

    assign any_grant = |grant;
    assign sel       = grant[MWb];
    assign sel_we    = m_req_we[sel];
    assign sel_last  = m_req_last[sel];
    assign sel_addr  = sel ? m_req_addr[ADDR_W +: ADDR_W]  : m_req_addr[0 +: ADDR_W];
    assign sel_wdata = sel ? m_req_wdata[DATA_W +: DATA_W] : m_req_wdata[0 +: DATA_W];
    assign sel_wmask = sel ? m_req_wmask[DATA_W +: DATA_W] : m_req_wmask[0 +: DATA_W];

    // VRAM buses are forced to zero whenever not carrying a granted beat.
    always_comb begin
        m_req_ready = grant;
        vram_r_ena  = any_grant & ~sel_we;
        vram_w_ena  = any_grant & sel_we;
        vram_r_addr = vram_r_ena ? sel_addr  : '0;
        vram_w_addr = vram_w_ena ? sel_addr  : '0;
        vram_w_data = vram_w_ena ? sel_wdata : '0;
        vram_w_mask = vram_w_ena ? sel_wmask : '0;
        m_rsp_valid = '0;
        if (tag_valid_q) begin
            m_rsp_valid[tag_id_q] = 1'b1;
        end
        m_rsp_data = tag_valid_q ? vram_r_data : '0;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        tag_valid_d = any_grant & ~sel_we;
        tag_id_d    = sel;
        if (any_grant) begin
            if (sel_last) begin
                state_d  = StIdle;
                rr_ptr_d = other_m(sel);
            end else begin
                state_d = StLock;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= MLsu;
            rr_ptr_q    <= MLsu;
            tag_valid_q <= 1'b0;
            tag_id_q    <= MLsu;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
        end
    end

endmodule

// File: tb/tb_v_vram_arbiter.sv
// Directed bench for v_vram_arbiter with a small write-first VRAM model.
module tb_v_vram_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   m_req_valid, m_req_ready, m_req_we, m_req_last, m_rsp_valid;
    logic [127:0] m_req_addr;
    logic [511:0] m_req_wdata, m_req_wmask;
    logic [255:0] m_rsp_data;
    logic         vram_r_ena, vram_w_ena;
    logic [63:0]  vram_r_addr, vram_w_addr;
    logic [255:0] vram_r_data = '0;
    logic [255:0] vram_w_data, vram_w_mask;

    int total = 0;
    int bad   = 0;

    logic [255:0] mem [logic [63:0]];
    logic [255:0] dvals [4];

    localparam logic [255:0] A5  = {32{8'hA5}};
    localparam logic [255:0] W11 = {32{8'h11}};
    localparam logic [255:0] W22 = {32{8'h22}};
    localparam logic [255:0] W33 = {32{8'h33}};
    localparam logic [255:0] W44 = {32{8'h44}};

    v_vram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_we    (m_req_we),
        .m_req_last  (m_req_last),
        .m_req_addr  (m_req_addr),
        .m_req_wdata (m_req_wdata),
        .m_req_wmask (m_req_wmask),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_data  (m_rsp_data),
        .vram_r_ena  (vram_r_ena),
        .vram_r_addr (vram_r_addr),
        .vram_r_data (vram_r_data),
        .vram_w_ena  (vram_w_ena),
        .vram_w_addr (vram_w_addr),
        .vram_w_data (vram_w_data),
        .vram_w_mask (vram_w_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rd_mem(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    always @(posedge clk) begin
        if (vram_w_ena) begin
            mem[vram_w_addr] = (rd_mem(vram_w_addr) & ~vram_w_mask) | (vram_w_data & vram_w_mask);
        end
        if (vram_r_ena) begin
            vram_r_data <= rd_mem(vram_r_addr);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic v, input logic we, input logic last,
                         input logic [63:0] addr, input logic [255:0] d);
        m_req_valid[m]           = v;
        m_req_we[m]              = we;
        m_req_last[m]            = last;
        m_req_addr[m*64 +: 64]   = addr;
        m_req_wdata[m*256 +: 256] = d;
        m_req_wmask[m*256 +: 256] = '1;
    endtask

    task automatic idle_all();
        m_req_valid = '0;
        m_req_we    = '0;
        m_req_last  = '0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_req_wmask = '0;
    endtask

    task automatic step_in();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        int cnt0;
        int cnt1;
        rst = 1'b1;
        idle_all();
        dvals[0] = {32{8'hD0}};
        dvals[1] = {32{8'hD1}};
        dvals[2] = {32{8'hD2}};
        dvals[3] = {32{8'hD3}};
        mem[64'h40] = A5;
        for (int k = 0; k < 4; k++) mem[64'h100 + 64'(k) * 64'h20] = dvals[k];

        // Reset and idle.
        repeat (2) @(posedge clk);
        sample();
        chk("rst_ready", 256'(m_req_ready), 256'(0));
        chk("rst_rsp_valid", 256'(m_rsp_valid), 256'(0));
        chk("rst_ena", 256'({vram_r_ena, vram_w_ena}), 256'(0));
        step_in();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("idle_ctrl", 256'({m_req_ready, m_rsp_valid, vram_r_ena, vram_w_ena}), 256'(0));
            chk("idle_bus", vram_w_data | vram_w_mask | m_rsp_data
                | 256'(vram_r_addr) | 256'(vram_w_addr), 256'(0));
        end

        // Single read by M0.
        step_in();
        drive(0, 1'b1, 1'b0, 1'b1, 64'h40, '0);
        sample();
        chk("rd_ready", 256'(m_req_ready), 256'(2'b01));
        chk("rd_r_ena", 256'(vram_r_ena), 256'(1));
        chk("rd_r_addr", 256'(vram_r_addr), 256'(64'h40));
        chk("rd_w_ena", 256'(vram_w_ena), 256'(0));
        step_in();
        idle_all();
        sample();
        chk("rd_rsp_valid", 256'(m_rsp_valid), 256'(2'b01));
        chk("rd_rsp_data", m_rsp_data, A5);
        step_in();
        sample();
        chk("rd_rsp_gone", 256'(m_rsp_valid), 256'(0));

        // Contention: M0 was served last, so M1 wins first, then strict alternation.
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 20; i++) begin
            step_in();
            drive(0, 1'b1, 1'b1, 1'b1, 64'h0, W11);
            drive(1, 1'b1, 1'b1, 1'b1, 64'h20, W22);
            sample();
            chk("cont_ready", 256'(m_req_ready), (i % 2 == 0) ? 256'(2'b10) : 256'(2'b01));
            chk("cont_w_addr", 256'(vram_w_addr), (i % 2 == 0) ? 256'(64'h20) : 256'(64'h0));
            chk("cont_w_data", vram_w_data, (i % 2 == 0) ? W22 : W11);
            if (m_req_ready[0]) cnt0++;
            if (m_req_ready[1]) cnt1++;
        end
        chk("cont_cnt0", 256'(cnt0), 256'(10));
        chk("cont_cnt1", 256'(cnt1), 256'(10));

        // M1 single write alone so the pointer favours M0 going into the burst.
        step_in();
        idle_all();
        drive(1, 1'b1, 1'b1, 1'b1, 64'h200, W22);
        sample();
        chk("pre_ready", 256'(m_req_ready), 256'(2'b10));

        // M1 4-beat read burst; M0 joins from beat 2 and must stay blocked.
        for (int b = 0; b < 4; b++) begin
            step_in();
            drive(1, 1'b1, 1'b0, b == 3, 64'h100 + 64'(b) * 64'h20, '0);
            drive(0, b > 0, 1'b0, 1'b1, 64'h40, '0);
            sample();
            chk("burst_ready", 256'(m_req_ready), 256'(2'b10));
            chk("burst_r_addr", 256'(vram_r_addr), 256'(64'h100 + 64'(b) * 64'h20));
            chk("burst_rsp_valid", 256'(m_rsp_valid), (b > 0) ? 256'(2'b10) : 256'(0));
            if (b > 0) chk("burst_rsp_data", m_rsp_data, dvals[b-1]);
        end
        step_in();
        drive(1, 1'b1, 1'b0, 1'b1, 64'h300, '0);
        drive(0, 1'b1, 1'b0, 1'b1, 64'h40, '0);
        sample();
        chk("after_burst_ready", 256'(m_req_ready), 256'(2'b01));
        chk("burst_last_rsp_valid", 256'(m_rsp_valid), 256'(2'b10));
        chk("burst_last_rsp_data", m_rsp_data, dvals[3]);
        step_in();
        idle_all();
        sample();
        chk("after_burst_rsp_valid", 256'(m_rsp_valid), 256'(2'b01));
        chk("after_burst_rsp_data", m_rsp_data, A5);

        // M0 write burst with a 2-cycle bubble; M1 waits with a read of the burst target.
        step_in();
        drive(0, 1'b1, 1'b1, 1'b0, 64'h400, W33);
        sample();
        chk("bub_b1_ready", 256'(m_req_ready), 256'(2'b01));
        chk("bub_b1_w_addr", 256'(vram_w_addr), 256'(64'h400));
        for (int i = 0; i < 2; i++) begin
            step_in();
            drive(0, 1'b0, 1'b1, 1'b1, 64'h420, W44);
            drive(1, 1'b1, 1'b0, 1'b1, 64'h420, '0);
            sample();
            chk("bub_ready", 256'(m_req_ready), 256'(0));
            chk("bub_ena", 256'({vram_r_ena, vram_w_ena}), 256'(0));
            chk("bub_bus", vram_w_data | vram_w_mask
                | 256'(vram_r_addr) | 256'(vram_w_addr), 256'(0));
        end
        step_in();
        drive(0, 1'b1, 1'b1, 1'b1, 64'h420, W44);
        sample();
        chk("bub_b2_ready", 256'(m_req_ready), 256'(2'b01));
        chk("bub_b2_w_addr", 256'(vram_w_addr), 256'(64'h420));
        chk("bub_b2_w_data", vram_w_data, W44);
        step_in();
        drive(0, 1'b0, 1'b0, 1'b0, 64'h0, '0);
        sample();
        chk("wr_rd_ready", 256'(m_req_ready), 256'(2'b10));
        chk("wr_rd_r_addr", 256'(vram_r_addr), 256'(64'h420));
        step_in();
        idle_all();
        sample();
        chk("wr_rd_rsp_valid", 256'(m_rsp_valid), 256'(2'b10));
        chk("wr_rd_rsp_data", m_rsp_data, W44);

        // Leave the pointer at M1 and a lock held by M0, then reset mid-burst.
        step_in();
        drive(0, 1'b1, 1'b0, 1'b1, 64'h40, '0);
        sample();
        chk("mr_single_ready", 256'(m_req_ready), 256'(2'b01));
        step_in();
        drive(0, 1'b1, 1'b0, 1'b0, 64'h40, '0);
        sample();
        chk("mr_burst_ready", 256'(m_req_ready), 256'(2'b01));
        step_in();
        rst = 1'b1;
        idle_all();
        sample();
        chk("mr_rsp_valid", 256'(m_rsp_valid), 256'(0));
        chk("mr_rsp_data", m_rsp_data, 256'(0));
        step_in();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b1, 64'h40, '0);
        drive(1, 1'b1, 1'b0, 1'b1, 64'h20, '0);
        sample();
        chk("mr_rsp_after", 256'(m_rsp_valid), 256'(0));
        chk("mr_regrant", 256'(m_req_ready), 256'(2'b01));
        step_in();
        idle_all();
        sample();
        chk("mr_final_rsp_valid", 256'(m_rsp_valid), 256'(2'b01));
        chk("mr_final_rsp_data", m_rsp_data, A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
